// File: rtl/calc1_sched_pkg.sv
// calc1_sched_pkg: command/response encodings, FSM and capture state types for the request scheduler
package calc1_sched_pkg;
   localparam int DEF_TIMEOUT = 16;
   localparam logic [3:0] CMD_ADD = 4'd1, CMD_SUB = 4'd2, CMD_SHL = 4'd5, CMD_SHR = 4'd6;
   localparam logic [1:0] RESP_NONE = 2'd0, RESP_OK = 2'd1, RESP_ERR = 2'd2, RESP_TMO = 2'd3;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RESP = 2'd2;
   typedef logic [1:0] cap_t;
   localparam cap_t CAP_IDLE = 2'd0, CAP_OP1 = 2'd1, CAP_PEND = 2'd2;
   function automatic logic cmd_valid(input logic [3:0] c);
      return c inside {CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR};
   endfunction
endpackage

// File: rtl/calc1_port_capture.sv
// calc1_port_capture: two-cycle command/operand capture for one requester, held pending until served
module calc1_port_capture
   import calc1_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  cmd_in,
   input  logic [31:0] data_in,
   input  logic        done,
   output logic        pending,
   output logic [3:0]  cmd,
   output logic [31:0] op1,
   output logic [31:0] op2
);
   cap_t st;
   always_ff @(posedge clk)
      if (rst) begin
         st  <= CAP_IDLE;
         cmd <= '0;
         op1 <= '0;
         op2 <= '0;
      end else begin
         if (st == CAP_IDLE && cmd_in != '0) begin
            st  <= CAP_OP1;
            cmd <= cmd_in;
            op1 <= data_in;
         end
         if (st == CAP_OP1) begin
            st  <= CAP_PEND;
            op2 <= data_in;
         end
         if (st == CAP_PEND && done) st <= CAP_IDLE;
      end
   assign pending = st == CAP_PEND;
endmodule

// File: rtl/calc1_req_scheduler.sv
// calc1_req_scheduler: four requesters sharing one ALU through a round-robin IDLE/ISSUE/RESP scheduler
module calc1_req_scheduler
   import calc1_sched_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [3:0]  req1_cmd_in,
   input  logic [3:0]  req2_cmd_in,
   input  logic [3:0]  req3_cmd_in,
   input  logic [3:0]  req4_cmd_in,
   input  logic [31:0] req1_data_in,
   input  logic [31:0] req2_data_in,
   input  logic [31:0] req3_data_in,
   input  logic [31:0] req4_data_in,
   output logic [1:0]  out_resp1,
   output logic [1:0]  out_resp2,
   output logic [1:0]  out_resp3,
   output logic [1:0]  out_resp4,
   output logic [31:0] out_data1,
   output logic [31:0] out_data2,
   output logic [31:0] out_data3,
   output logic [31:0] out_data4,
   output logic        alu_req_out,
   output logic [3:0]  alu_cmd_out,
   output logic [31:0] alu_op1_out,
   output logic [31:0] alu_op2_out,
   input  logic        alu_ack_in,
   input  logic [1:0]  alu_resp_in,
   input  logic [31:0] alu_data_in
);
   logic [3:0]  cmd_in [4];
   logic [31:0] data_in [4];
   logic [3:0]  cmd [4];
   logic [31:0] op1 [4];
   logic [31:0] op2 [4];
   logic [1:0]  resp_o [4];
   logic [31:0] data_o [4];
   logic [3:0]  pending, done;
   state_t      state;
   logic [1:0]  grant, last, sel;
   logic        found;
   logic [1:0]  resp_q;
   logic [31:0] data_q;
   logic [15:0] timer;
   assign cmd_in  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
   assign data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
   for (genvar g = 0; g < 4; g++) begin : g_port
      calc1_port_capture u_cap (
         .clk(c_clk), .rst(reset), .cmd_in(cmd_in[g]), .data_in(data_in[g]), .done(done[g]),
         .pending(pending[g]), .cmd(cmd[g]), .op1(op1[g]), .op2(op2[g])
      );
      assign done[g]   = state == ST_RESP && grant == 2'(g);
      assign resp_o[g] = done[g] ? resp_q : RESP_NONE;
      assign data_o[g] = done[g] ? data_q : '0;
   end
   assign {out_resp1, out_resp2, out_resp3, out_resp4} = {resp_o[0], resp_o[1], resp_o[2], resp_o[3]};
   assign {out_data1, out_data2, out_data3, out_data4} = {data_o[0], data_o[1], data_o[2], data_o[3]};
   // Search starts one past the last grant; k == 4 wraps back onto the last granted port itself.
   always_comb begin
      sel   = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++)
         if (!found && pending[last + 2'(k)]) begin
            sel   = last + 2'(k);
            found = 1'b1;
         end
   end
   always_ff @(posedge c_clk)
      if (reset) begin
         state  <= ST_IDLE;
         grant  <= '0;
         last   <= 2'd3;
         resp_q <= RESP_NONE;
         data_q <= '0;
         timer  <= '0;
      end else
         case (state)
            ST_IDLE:
               if (found) begin
                  grant  <= sel;
                  last   <= sel;
                  timer  <= '0;
                  resp_q <= RESP_ERR;
                  data_q <= '0;
                  state  <= cmd_valid(cmd[sel]) ? ST_ISSUE : ST_RESP;
               end
            ST_ISSUE:
               if (alu_ack_in) begin
                  resp_q <= alu_resp_in;
                  data_q <= alu_data_in;
                  state  <= ST_RESP;
               end else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
                  resp_q <= RESP_TMO;
                  data_q <= '0;
                  state  <= ST_RESP;
               end else
                  timer <= timer + 16'd1;
            default: state <= ST_IDLE;
         endcase
   assign alu_req_out = state == ST_ISSUE;
   assign alu_cmd_out = alu_req_out ? cmd[grant] : '0;
   assign alu_op1_out = alu_req_out ? op1[grant] : '0;
   assign alu_op2_out = alu_req_out ? op2[grant] : '0;
endmodule

// File: tb/tb_calc1_req_scheduler.sv
// tb_calc1_req_scheduler: randomized scoreboard bench with an ALU responder and per-port expected queues
module tb_calc1_req_scheduler;
   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  cmd_drv [4];
   logic [31:0] data_drv [4];
   logic [1:0]  resp_w [4];
   logic [31:0] odata_w [4];
   logic        alu_req_out;
   logic [3:0]  alu_cmd_out;
   logic [31:0] alu_op1_out, alu_op2_out;
   logic        alu_ack_in = 1'b0;
   logic [1:0]  alu_resp_in = 2'd0;
   logic [31:0] alu_data_in = 32'd0;
   int          checks = 0, errors = 0, cyc = 0;
   logic        alu_en = 1'b1;
   int          min_delay = 0, max_delay = 0;
   logic [33:0] exp_q [4][$];
   logic        busy [4];
   int          order_q [$];
   logic [3:0]  ic [4];
   logic [31:0] ia [4], ib [4];

   calc1_req_scheduler dut (
      .c_clk(c_clk), .reset(reset),
      .req1_cmd_in(cmd_drv[0]), .req2_cmd_in(cmd_drv[1]), .req3_cmd_in(cmd_drv[2]), .req4_cmd_in(cmd_drv[3]),
      .req1_data_in(data_drv[0]), .req2_data_in(data_drv[1]), .req3_data_in(data_drv[2]), .req4_data_in(data_drv[3]),
      .out_resp1(resp_w[0]), .out_resp2(resp_w[1]), .out_resp3(resp_w[2]), .out_resp4(resp_w[3]),
      .out_data1(odata_w[0]), .out_data2(odata_w[1]), .out_data3(odata_w[2]), .out_data4(odata_w[3]),
      .alu_req_out(alu_req_out), .alu_cmd_out(alu_cmd_out), .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out),
      .alu_ack_in(alu_ack_in), .alu_resp_in(alu_resp_in), .alu_data_in(alu_data_in)
   );

   always #5 c_clk = ~c_clk;
   always @(posedge c_clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'd1: return a + b;
         4'd2: return a - b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [33:0] exp_of(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic en);
      if (!(c inside {4'd1, 4'd2, 4'd5, 4'd6})) return {2'd2, 32'd0};
      return en ? {2'd1, alu_f(c, a, b)} : {2'd3, 32'd0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // ALU model: acks after a random delay while requested, and toggles junk on its return port otherwise
   initial begin
      int wait_n;
      wait_n = 0;
      forever begin
         @(negedge c_clk);
         if (!alu_en) alu_ack_in = 1'b0;
         else if (!alu_req_out) begin
            alu_ack_in  = 1'($urandom_range(0, 1));
            alu_resp_in = 2'($urandom);
            alu_data_in = $urandom;
            wait_n      = $urandom_range(min_delay, max_delay);
         end else if (wait_n > 0) begin
            wait_n--;
            alu_ack_in  = 1'b0;
            alu_data_in = $urandom;
         end else begin
            alu_ack_in  = 1'b1;
            alu_resp_in = 2'd1;
            alu_data_in = alu_f(alu_cmd_out, alu_op1_out, alu_op2_out);
         end
      end
   end

   // Monitor: pops the port's expected response whenever the DUT presents one
   initial forever begin
      int n;
      logic [33:0] e;
      @(negedge c_clk);
      n = 0;
      for (int p = 0; p < 4; p++)
         if (resp_w[p] != 2'd0) begin
            n++;
            order_q.push_back(p);
            if (exp_q[p].size() == 0) chk($sformatf("unexpected_resp_p%0d", p + 1), {resp_w[p], odata_w[p]}, 64'd0);
            else begin
               e = exp_q[p].pop_front();
               chk($sformatf("resp_p%0d", p + 1), {resp_w[p], odata_w[p]}, 64'(e));
               busy[p] = 1'b0;
            end
         end else if (odata_w[p] != 32'd0) chk($sformatf("idle_data_p%0d", p + 1), odata_w[p], 64'd0);
      if (n > 1) chk("resp_overlap", n, 1);
      if (!alu_req_out && {alu_cmd_out, alu_op1_out, alu_op2_out} != '0)
         chk("alu_idle_zero", {alu_cmd_out, alu_op1_out, alu_op2_out}, 64'd0);
   end

   task automatic issue_set(input logic [3:0] mask, output int t0);
      @(negedge c_clk); #1;
      t0 = cyc;
      for (int p = 0; p < 4; p++)
         if (mask[p]) begin
            cmd_drv[p]  = ic[p];
            data_drv[p] = ia[p];
            exp_q[p].push_back(exp_of(ic[p], ia[p], ib[p], alu_en));
            busy[p] = 1'b1;
         end
      @(negedge c_clk); #1;
      for (int p = 0; p < 4; p++)
         if (mask[p]) begin
            cmd_drv[p]  = 4'd0;
            data_drv[p] = ib[p];
         end
      @(negedge c_clk); #1;
      for (int p = 0; p < 4; p++)
         if (mask[p]) data_drv[p] = $urandom;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 600) begin
         @(negedge c_clk); #1;
         n++;
      end
      if (n >= 600) begin
         chk("drain_timeout", n, 0);
         for (int p = 0; p < 4; p++) begin
            exp_q[p].delete();
            busy[p] = 1'b0;
         end
      end
   endtask

   initial begin
      int t0, n, seen;
      logic [3:0] mask;
      logic [3:0] vl [4];
      logic [3:0] il [4];
      vl = '{4'd1, 4'd2, 4'd5, 4'd6};
      il = '{4'd3, 4'd4, 4'd7, 4'd15};
      for (int p = 0; p < 4; p++) begin
         cmd_drv[p]  = 4'd0;
         data_drv[p] = 32'd0;
         busy[p]     = 1'b0;
      end
      repeat (3) @(negedge c_clk);
      chk("reset_resp", {resp_w[0], resp_w[1], resp_w[2], resp_w[3]}, 64'd0);
      chk("reset_alu", {alu_req_out, alu_cmd_out, alu_op1_out}, 64'd0);
      #1 reset = 1'b0;
      // all four ports at once, twice: expect 1,2,3,4 each round
      max_delay = 2;
      for (int r = 0; r < 2; r++) begin
         order_q.delete();
         for (int p = 0; p < 4; p++) begin
            ic[p] = 4'd1;
            ia[p] = $urandom;
            ib[p] = $urandom;
         end
         issue_set(4'hf, t0);
         wait_done();
         chk($sformatf("rr_order_round%0d", r + 1), {order_q.size(), 32'(order_q.size() == 4 ? order_q[0] * 1000 + order_q[1] * 100 + order_q[2] * 10 + order_q[3] : -1)}, {32'd4, 32'd123});
      end
      // minimum latency
      max_delay = 0;
      ic[0] = 4'd1; ia[0] = 32'h5; ib[0] = 32'h3;
      issue_set(4'b0001, t0);
      n = 0;
      while (!alu_req_out && n < 20) begin @(negedge c_clk); n++; end
      chk("req_rise_cycle", cyc - t0, 3);
      chk("alu_fwd", {alu_cmd_out, alu_op1_out, alu_op2_out}, {4'd1, 32'h5, 32'h3});
      @(negedge c_clk);
      chk("resp1_cycle", {cyc - t0, 30'd0, resp_w[0], odata_w[0]}, {32'd4, 30'd0, 2'd1, 32'h8});
      @(negedge c_clk);
      chk("resp1_one_cycle", resp_w[0], 0);
      wait_done();
      // invalid command never reaches the ALU
      max_delay = 2;
      ic[2] = 4'd4; ia[2] = $urandom; ib[2] = $urandom;
      issue_set(4'b0100, t0);
      seen = 0;
      repeat (10) begin @(negedge c_clk); if (alu_req_out) seen++; end
      chk("invalid_no_req", seen, 0);
      wait_done();
      // timeout with no ack
      alu_en = 1'b0;
      ic[1] = 4'd2; ia[1] = $urandom; ib[1] = $urandom;
      issue_set(4'b0010, t0);
      n = 0; seen = 0;
      while (resp_w[1] == 2'd0 && n < 80) begin
         @(negedge c_clk);
         n++;
         if (alu_req_out) seen++;
      end
      chk("timeout_req_cycles", seen, 16);
      wait_done();
      alu_en = 1'b1;
      // re-issue on a pending port is ignored; port4 waits and is served next
      min_delay = 3; max_delay = 3;
      order_q.delete();
      ic[0] = 4'd5; ia[0] = $urandom; ib[0] = 32'd4;
      issue_set(4'b0001, t0);
      cmd_drv[0] = 4'd1; data_drv[0] = $urandom;
      @(negedge c_clk); #1;
      cmd_drv[0] = 4'd0;
      ic[3] = 4'd2; ia[3] = $urandom; ib[3] = $urandom;
      cmd_drv[3] = ic[3]; data_drv[3] = ia[3];
      exp_q[3].push_back(exp_of(ic[3], ia[3], ib[3], 1'b1));
      busy[3] = 1'b1;
      @(negedge c_clk); #1;
      cmd_drv[3] = 4'd0; data_drv[3] = ib[3];
      wait_done();
      repeat (5) @(negedge c_clk);
      chk("reissue_order", {order_q.size(), 32'(order_q.size() == 2 ? order_q[0] * 10 + order_q[1] : -1)}, {32'd2, 32'd3});
      min_delay = 0;
      // reset in the second ISSUE cycle discards the command
      alu_en = 1'b0;
      ic[0] = 4'd1; ia[0] = $urandom; ib[0] = $urandom;
      issue_set(4'b0001, t0);
      n = 0;
      while (!alu_req_out && n < 20) begin @(negedge c_clk); n++; end
      @(negedge c_clk); #1;
      reset = 1'b1;
      exp_q[0].delete();
      busy[0] = 1'b0;
      @(negedge c_clk);
      chk("reset_drops_req", alu_req_out, 0);
      #1 reset = 1'b0;
      seen = 0;
      repeat (20) begin @(negedge c_clk); for (int p = 0; p < 4; p++) if (resp_w[p] != 2'd0) seen++; end
      chk("reset_no_resp", seen, 0);
      alu_en = 1'b1;
      ic[0] = 4'd6; ia[0] = 32'h8000_0000; ib[0] = 32'd31;
      issue_set(4'b0001, t0);
      wait_done();
      // randomized traffic
      max_delay = 3;
      for (int it = 0; it < 200; it++) begin
         mask = '0;
         for (int p = 0; p < 4; p++)
            if (!busy[p] && resp_w[p] == 2'd0 && $urandom_range(0, 2) == 0) begin
               mask[p] = 1'b1;
               ic[p] = ($urandom_range(0, 3) == 0) ? il[$urandom_range(0, 3)] : vl[$urandom_range(0, 3)];
               ia[p] = $urandom;
               ib[p] = $urandom;
            end
         if (mask != '0) issue_set(mask, t0);
         repeat ($urandom_range(0, 3)) begin @(negedge c_clk); #1; end
      end
      wait_done();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
